// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for a multicycle MIPS datapath. Steps each
// instruction through fetch / decode / execute / memory / write-back,
// stalls in the memory states on in_mem_ready, latches the opcode in DECODE
// and flags unknown opcodes with a sticky out_illegal bit.
//
// Optional feature macro: MC_ZERO_EXT_EN
//   defined   : andi/ori are decoded (I_EXEC/I_WB, alu_op = 11, zero-extend)
//   undefined : andi/ori are unknown opcodes, out_ext_zero is constant 0
//
// Ports
//   in_clock           system clock, rising edge
//   in_reset           asynchronous, active-high reset
//   in_opcode[5:0]     IR[31:26], valid from the DECODE cycle on
//   in_mem_ready       memory completes the current access this cycle
//   out_pc_write       unconditional PC load
//   out_pc_write_cond  PC load if ALU zero
//   out_i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   out_mem_read       memory read request
//   out_mem_write      memory write request
//   out_ir_write       IR load
//   out_mem_to_reg     register write data: 0 = ALUOut, 1 = MDR
//   out_reg_dst        destination register: 0 = rt, 1 = rd
//   out_reg_write      register file write
//   out_alu_src_a      0 = PC, 1 = A
//   out_alu_src_b[1:0] 00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2
//   out_alu_op[1:0]    00 = add, 01 = sub, 10 = funct, 11 = logical by opcode
//   out_pc_source[1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   out_ext_zero       1 = zero-extend immediate, 0 = sign-extend
//   out_illegal        sticky unknown-opcode flag
//   out_state[3:0]     current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic [5:0] in_opcode,
    input  logic       in_mem_ready,
    output logic       out_pc_write,
    output logic       out_pc_write_cond,
    output logic       out_i_or_d,
    output logic       out_mem_read,
    output logic       out_mem_write,
    output logic       out_ir_write,
    output logic       out_mem_to_reg,
    output logic       out_reg_dst,
    output logic       out_reg_write,
    output logic       out_alu_src_a,
    output logic [1:0] out_alu_src_b,
    output logic [1:0] out_alu_op,
    output logic [1:0] out_pc_source,
    output logic       out_ext_zero,
    output logic       out_illegal,
    output logic [3:0] out_state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_ZERO_EXT_EN
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;

    // Raw (pre-reset-gating) control decode
    logic       c_pc_write;
    logic       c_pc_write_cond;
    logic       c_i_or_d;
    logic       c_mem_read;
    logic       c_mem_write;
    logic       c_ir_write;
    logic       c_mem_to_reg;
    logic       c_reg_dst;
    logic       c_reg_write;
    logic       c_alu_src_a;
    logic [1:0] c_alu_src_b;
    logic [1:0] c_alu_op;
    logic [1:0] c_pc_source;
    logic       c_ext_zero;

    // Latched instruction is a zero-extended logical immediate op
    logic       logic_imm_op;

`ifdef MC_ZERO_EXT_EN
    assign logic_imm_op = (opcode_q == OP_ANDI) || (opcode_q == OP_ORI);
`else
    assign logic_imm_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, opcode and illegal-flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_FETCH: begin
                if (in_mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Dispatch on the live opcode; later states use the latched copy.
                opcode_d = in_opcode;
                case (in_opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
`ifdef MC_ZERO_EXT_EN
                    OP_ANDI,
                    OP_ORI:       state_d = S_I_EXEC;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                // Only lw/sw reach this state, so anything but lw is a store.
                state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                if (in_mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WRITE: begin
                if (in_mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_MEM_WB:  state_d = S_FETCH;
            S_R_EXEC:  state_d = S_R_WB;
            S_R_WB:    state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_I_EXEC:  state_d = S_I_WB;
            S_I_WB:    state_d = S_FETCH;

            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Control output decode (Moore, plus in_mem_ready in FETCH)
    // ------------------------------------------------------------------
    always_comb begin
        c_pc_write      = 1'b0;
        c_pc_write_cond = 1'b0;
        c_i_or_d        = 1'b0;
        c_mem_read      = 1'b0;
        c_mem_write     = 1'b0;
        c_ir_write      = 1'b0;
        c_mem_to_reg    = 1'b0;
        c_reg_dst       = 1'b0;
        c_reg_write     = 1'b0;
        c_alu_src_a     = 1'b0;
        c_alu_src_b     = 2'b00;
        c_alu_op        = 2'b00;
        c_pc_source     = 2'b00;
        c_ext_zero      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                c_mem_read  = 1'b1;
                c_alu_src_b = 2'b01;
                // PC and IR load only on the cycle the fetch completes
                c_pc_write  = in_mem_ready;
                c_ir_write  = in_mem_ready;
            end

            S_DECODE: begin
                c_alu_src_b = 2'b11;
            end

            S_MEM_ADDR: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
            end

            S_MEM_READ: begin
                c_mem_read = 1'b1;
                c_i_or_d   = 1'b1;
            end

            S_MEM_WB: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
            end

            S_MEM_WRITE: begin
                c_mem_write = 1'b1;
                c_i_or_d    = 1'b1;
            end

            S_R_EXEC: begin
                c_alu_src_a = 1'b1;
                c_alu_op    = 2'b10;
            end

            S_R_WB: begin
                c_reg_write = 1'b1;
                c_reg_dst   = 1'b1;
            end

            S_BRANCH: begin
                c_alu_src_a     = 1'b1;
                c_alu_op        = 2'b01;
                c_pc_write_cond = 1'b1;
                c_pc_source     = 2'b01;
            end

            S_JUMP: begin
                c_pc_write  = 1'b1;
                c_pc_source = 2'b10;
            end

            S_I_EXEC: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
                c_alu_op    = logic_imm_op ? 2'b11 : 2'b00;
                c_ext_zero  = logic_imm_op;
            end

            S_I_WB: begin
                c_reg_write = 1'b1;
                c_ext_zero  = logic_imm_op;
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: reset forces every control low even though the state
    // register already sits in FETCH (whose decode is not all-zero).
    // ------------------------------------------------------------------
    always_comb begin
        out_pc_write      = c_pc_write      & ~in_reset;
        out_pc_write_cond = c_pc_write_cond & ~in_reset;
        out_i_or_d        = c_i_or_d        & ~in_reset;
        out_mem_read      = c_mem_read      & ~in_reset;
        out_mem_write     = c_mem_write     & ~in_reset;
        out_ir_write      = c_ir_write      & ~in_reset;
        out_mem_to_reg    = c_mem_to_reg    & ~in_reset;
        out_reg_dst       = c_reg_dst       & ~in_reset;
        out_reg_write     = c_reg_write     & ~in_reset;
        out_alu_src_a     = c_alu_src_a     & ~in_reset;
        out_alu_src_b     = in_reset ? 2'b00 : c_alu_src_b;
        out_alu_op        = in_reset ? 2'b00 : c_alu_op;
        out_pc_source     = in_reset ? 2'b00 : c_pc_source;
        out_ext_zero      = c_ext_zero      & ~in_reset;
    end

    assign out_illegal = illegal_q;
    assign out_state   = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style finite state machine that sequences the multicycle MIPS datapath: PC, instruction register, unified memory, register file, ALU and the immediate sign-extension unit. It decodes the 6-bit opcode, steps each instruction through fetch/decode/execute/memory/write-back states, and stalls on a memory ready handshake. It also selects between sign and zero extension of the 16-bit immediate.

## Interface
- No parameters.
- in_clock  in  1  system clock, rising edge
- in_reset  in  1  asynchronous, active-high reset
- in_opcode  in  6  IR[31:26]; stable from the cycle after the IR write
- in_mem_ready  in  1  memory completes the current access this cycle
- out_pc_write  out  1  unconditional PC load
- out_pc_write_cond  out  1  PC load if ALU zero
- out_i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- out_mem_read  out  1  memory read request
- out_mem_write  out  1  memory write request
- out_ir_write  out  1  IR load
- out_mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- out_reg_dst  out  1  destination register: 0 = rt, 1 = rd
- out_reg_write  out  1  register file write
- out_alu_src_a  out  1  0 = PC, 1 = A
- out_alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext(imm), 11 = ext(imm)<<2
- out_alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = logical by opcode
- out_pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- out_ext_zero  out  1  1 = zero-extend the immediate, 0 = sign-extend
- out_illegal  out  1  sticky unknown-opcode flag
- out_state  out  4  current state code (debug)

## Operation
- Opcodes:
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010
  - addi = 001000
  - andi = 001100 (macro only)
  - ori = 001101 (macro only)
- State codes:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - pc_write and ir_write are asserted only while in_mem_ready = 1.
  - Goes to DECODE when in_mem_ready = 1; otherwise stays.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target computed).
  - Latches in_opcode into an internal register; all later states use the latched copy.
  - Next state by opcode: lw/sw → MEM_ADDR; R → R_EXEC; beq → BRANCH; j → JUMP; addi/andi/ori → I_EXEC.
  - Unknown opcode → FETCH, and out_illegal is set on that edge.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Goes to MEM_WB when in_mem_ready = 1.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEM_WRITE:
  - mem_write = 1, i_or_d = 1 are held until in_mem_ready = 1.
  - Goes to FETCH when in_mem_ready = 1.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Goes to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Goes to FETCH.
- I_EXEC:
  - alu_src_a = 1, alu_src_b = 10.
  - alu_op = 00 for addi, 11 for andi/ori.
  - Goes to I_WB.
- I_WB:
  - reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - out_ext_zero is held over I_EXEC and I_WB.
  - Goes to FETCH.
- Any control output not listed for a state is 0.
- out_ext_zero is 1 only in I_EXEC/I_WB of andi/ori; it is 0 everywhere else, including the sign-extended offsets of lw/sw/beq.

## Timing
- out_state, the latched opcode and out_illegal are registers. All control outputs decode combinationally from the registered state, plus in_mem_ready in the handshake states.
- Cycles per instruction with in_mem_ready tied to 1:
  - lw: 5
  - sw, R-type, addi, andi, ori: 4
  - beq, j: 3
  - unknown opcode: 2
- Each memory state adds one cycle for each cycle in_mem_ready = 0. Request outputs stay constant while waiting.
- in_mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Reset:
  - Asserting in_reset takes effect immediately, at any point including mid-instruction or mid-stall.
  - The FSM goes to FETCH, the opcode register to 000000, out_illegal to 0.
  - While in_reset = 1, every control output is forced to 0 and out_state = 0.
  - The first rising edge after deassertion is evaluated from FETCH.
- out_illegal stays set until reset. A later valid instruction does not clear it.

## Configuration
- MC_ZERO_EXT_EN defined: andi/ori decode to I_EXEC, with alu_op = 11 and out_ext_zero = 1.
- MC_ZERO_EXT_EN undefined: andi/ori are unknown opcodes (DECODE → FETCH, out_illegal set), and out_ext_zero is constant 0.

## Test plan
- Reset mid-MEM_READ with in_mem_ready = 0 → out_state = 0 immediately and all controls 0. After release with ready = 1, out_state sequence is 0, 1.
- lw (100011), ready = 1 → states 0, 1, 2, 3, 4, 0. reg_write = 1 and mem_to_reg = 1 only in state 4.
- sw with ready held 0 for 3 cycles in MEM_WRITE → mem_write = 1 for 4 cycles, then FETCH. reg_write is never 1.
- beq then j → states 0, 1, 8, 0, 1, 9, 0. pc_write_cond = 1 only in state 8, pc_source = 10 in state 9.
- Opcode 111111 → DECODE → FETCH and out_illegal = 1. A following R-type (states 0, 1, 6, 7) still runs, with out_illegal still 1.
- ori (001101): with MC_ZERO_EXT_EN → states 10, 11 with out_ext_zero = 1 and alu_op = 11. Without it → out_illegal = 1, and out_ext_zero is never 1.
